// File: rtl/wordlist_pkg.sv
// rtl/wordlist_pkg.sv - shared types and constants for the flash word-list search
package wordlist_pkg;

  localparam int LETTER_W    = 5;
  localparam int WORD_W      = 5 * LETTER_W;
  localparam int ENTRY_BYTES = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    WAIT,
    CMP,
    FINISH
  } state_t;

endpackage

// File: rtl/wordlist_search.sv
// rtl/wordlist_search.sv - binary search of a sorted flash word list via 32-bit fetches
module wordlist_search
  import wordlist_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h100000,
  parameter int          LIST_LEN  = 2315,
  parameter int          IDX_W     = 12,
  parameter int          TIMEOUT   = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [24:0]      query_word,
  input  logic             query_start,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] found_index,
  output logic             error,
  output logic [23:0]      fetch_addr,
  output logic             fetch,
  input  logic [31:0]      fetch_result,
  input  logic             fetch_done
);

  localparam int TCNT_W     = $clog2(TIMEOUT + 1);
  localparam int ADDR_SHIFT = $clog2(ENTRY_BYTES);

  state_t                  state;
  logic signed [IDX_W:0]   lo;
  logic signed [IDX_W:0]   hi;
  word_t                   key;
  word_t                   entry;
  logic [IDX_W-1:0]        mid;
  logic [TCNT_W-1:0]       tcnt;

  // Sum is one bit wider than lo/hi so the midpoint never overflows.
  logic [IDX_W+1:0]        bound_sum;
  logic [IDX_W-1:0]        mid_next;
  logic                    unused_hi;

  assign bound_sum = {1'b0, lo} + {1'b0, hi};
  assign mid_next  = bound_sum[IDX_W:1];
  assign unused_hi = ^fetch_result[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= '0;
      key         <= '0;
      entry       <= '0;
      mid         <= '0;
      tcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_index <= '0;
      error       <= 1'b0;
      fetch_addr  <= '0;
      fetch       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (query_start) begin
            key         <= query_word;
            lo          <= '0;
            hi          <= (IDX_W+1)'(LIST_LEN - 1);
            found       <= 1'b0;
            found_index <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            state       <= PROBE;
          end
        end
        PROBE: begin
          if (lo > hi) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            mid        <= mid_next;
            fetch_addr <= BASE_ADDR + (24'(mid_next) << ADDR_SHIFT);
            fetch      <= 1'b1;
            tcnt       <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (fetch_done) begin
            fetch <= 1'b0;
            entry <= fetch_result[24:0];
            state <= CMP;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            fetch <= 1'b0;
            error <= 1'b1;
            found <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CMP: begin
          if (entry == key) begin
            found       <= 1'b1;
            found_index <= mid;
            done        <= 1'b1;
            state       <= FINISH;
          end else if (entry < key) begin
            lo    <= {1'b0, mid} + (IDX_W+1)'(1);
            state <= PROBE;
          end else begin
            hi    <= {1'b0, mid} - (IDX_W+1)'(1);
            state <= PROBE;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wordlist_search.sv
// tb/tb_wordlist_search.sv - self-checking bench with a flash model for wordlist_search
module tb_wordlist_search;
  import wordlist_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = 12;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [24:0]      query_word;
  logic             query_start;
  logic             busy, done, found, error, fetch, fetch_done;
  logic [IDX_W-1:0] found_index;
  logic [23:0]      fetch_addr;
  logic [31:0]      fetch_result;

  always #5 clk = ~clk;

  wordlist_search #(
    .BASE_ADDR(24'h000000), .LIST_LEN(N), .IDX_W(IDX_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .query_word(query_word), .query_start(query_start),
    .busy(busy), .done(done), .found(found), .found_index(found_index),
    .error(error), .fetch_addr(fetch_addr), .fetch(fetch),
    .fetch_result(fetch_result), .fetch_done(fetch_done)
  );

  int tests = 0;
  int fails = 0;

  // Flash model: sorted list 0x10..0x80, responds lat cycles after fetch rises.
  int          lat = 5;
  bit          no_resp = 1'b0;
  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        prev_fetch = 1'b0;
  logic [23:0] held_addr;
  logic [23:0] addrs[$];
  int          fcnt = 0;
  int          high_cycles = 0;
  bit          addr_unstable = 1'b0;

  assign fetch_done = model_done | spur_done;

  function automatic word_t list_entry(int i);
    return word_t'((i + 1) * 16);
  endfunction

  function automatic word_t flash_word(logic [23:0] a);
    if (a[1:0] != 2'b00 || int'(a >> 2) >= N) return 25'h1ffffff;
    return list_entry(int'(a >> 2));
  endfunction

  initial fetch_result = 32'h0;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (fetch) begin
      if (!prev_fetch) begin
        addrs.push_back(fetch_addr);
        held_addr = fetch_addr;
        fcnt = 0;
      end else if (fetch_addr != held_addr) begin
        addr_unstable = 1'b1;
      end
      high_cycles++;
      fcnt++;
      if (fcnt == lat && !no_resp) begin
        model_done   = 1'b1;
        fetch_result = {7'h5a, flash_word(fetch_addr)};
      end
    end
    prev_fetch = fetch;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  bit          r_found, r_err, r_tmo, r_busy_after;
  int          r_idx;

  task automatic run_query(input word_t q, input bit extra);
    int n;
    @(negedge clk);
    addrs.delete();
    high_cycles   = 0;
    addr_unstable = 1'b0;
    query_word    = q;
    query_start   = 1'b1;
    @(negedge clk);
    query_start = 1'b0;
    if (extra) begin
      query_word  = 25'h0001234;
      query_start = 1'b1;
      @(negedge clk);
      query_start = 1'b0;
    end
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    r_tmo   = !done;
    r_found = found;
    r_idx   = int'(found_index);
    r_err   = error;
    @(negedge clk);
    r_busy_after = busy;
  endtask

  typedef struct {
    word_t       q;
    bit          f;
    int          idx;
    int          probes;
    logic [23:0] last_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vec_t v;
    int   exp_idx;
    bit   exp_f;
    int   bad;
    int   n;

    rst = 1'b1; query_word = '0; query_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fetch", fetch, 0);
    check("reset_outs", {found, error, found_index, fetch_addr}, 0);
    rst = 1'b0;

    vecs[0] = '{25'h40, 1'b1, 3, 1, 24'h0c};
    vecs[1] = '{25'h05, 1'b0, 0, 3, 24'h00};
    vecs[2] = '{25'h90, 1'b0, 0, 4, 24'h1c};
    vecs[3] = '{25'h10, 1'b1, 0, 3, 24'h00};
    vecs[4] = '{25'h80, 1'b1, 7, 4, 24'h1c};
    vecs[5] = '{25'h45, 1'b0, 0, 3, 24'h10};

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      run_query(v.q, 1'b0);
      check($sformatf("v%0d_timeout", i), r_tmo, 0);
      check($sformatf("v%0d_found", i), r_found, v.f);
      check($sformatf("v%0d_index", i), r_idx, v.idx);
      check($sformatf("v%0d_error", i), r_err, 0);
      check($sformatf("v%0d_probes", i), addrs.size(), v.probes);
      check($sformatf("v%0d_first_addr", i), addrs.size() > 0 ? addrs[0] : 24'hffffff, 24'h0c);
      check($sformatf("v%0d_last_addr", i), addrs.size() > 0 ? addrs[$] : 24'hffffff, v.last_addr);
      check($sformatf("v%0d_addr_stable", i), addr_unstable, 0);
      check($sformatf("v%0d_busy_after", i), r_busy_after, 0);
    end

    // Timeout: flash never answers.
    no_resp = 1'b1;
    run_query(25'h40, 1'b0);
    check("tmo_done_seen", r_tmo, 0);
    check("tmo_error", r_err, 1);
    check("tmo_found", r_found, 0);
    check("tmo_fetch_cycles", high_cycles, TMO);
    check("tmo_probes", addrs.size(), 1);
    check("tmo_busy_after", r_busy_after, 0);
    check("tmo_fetch_low", fetch, 0);
    no_resp = 1'b0;

    // Reset during the second probe's WAIT.
    @(negedge clk);
    addrs.delete();
    query_word = 25'h80; query_start = 1'b1;
    @(negedge clk);
    query_start = 1'b0;
    n = 0;
    while (!(addrs.size() == 2 && fetch) && n < 200) begin @(negedge clk); n++; end
    check("rst_reached_wait2", addrs.size() == 2 && fetch, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outs", {busy, done, found, error, fetch, found_index, fetch_addr}, 0);
    bad = 0;
    repeat (10) begin @(negedge clk); if (done || busy || fetch) bad++; end
    check("rst_quiet", bad, 0);
    run_query(25'h80, 1'b0);
    check("post_rst_found", r_found, 1);
    check("post_rst_index", r_idx, 7);

    // Spurious fetch_done in IDLE, then an extra query_start while busy.
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_idle_busy", busy, 0);
    run_query(25'h40, 1'b1);
    check("extra_found", r_found, 1);
    check("extra_index", r_idx, 3);
    check("extra_probes", addrs.size(), 1);

    // Randomized queries against a linear-scan membership model.
    for (int k = 0; k < 40; k++) begin
      word_t q;
      lat = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) q = list_entry($urandom_range(0, N - 1));
      else q = word_t'($urandom_range(0, 'ha0));
      exp_f = 1'b0; exp_idx = 0;
      for (int j = 0; j < N; j++)
        if (list_entry(j) == q) begin exp_f = 1'b1; exp_idx = j; end
      run_query(q, 1'b0);
      bad = 0;
      foreach (addrs[j]) if (addrs[j] >= 24'h20 || addrs[j][1:0] != 2'b00) bad++;
      check($sformatf("rnd%0d_found q=%0h", k, q), r_found, exp_f);
      check($sformatf("rnd%0d_index q=%0h", k, q), r_idx, exp_idx);
      check($sformatf("rnd%0d_error", k), r_err | r_tmo, 0);
      check($sformatf("rnd%0d_probe_limit", k), addrs.size() <= 4, 1);
      check($sformatf("rnd%0d_addr_range", k), bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
